// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control/data words seen by the MEM stage,
// LSU state encoding and access-size decode.
package rv32i_types;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MBE_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       dmem_read;
        logic       dmem_write;
        logic [2:0] funct3;
    } rv32i_control_word;

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] rs2_out;
    } rv32i_data_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Access width from funct3; anything not a legal byte/half encoding is a word.
    function automatic acc_size_t acc_size(input logic [2:0] funct3, input logic is_store);
        acc_size_t sz;
        sz = SZ_WORD;
        if (funct3 == F3_B || (!is_store && funct3 == F3_BU))
            sz = SZ_BYTE;
        else if (funct3 == F3_H || (!is_store && funct3 == F3_HU))
            sz = SZ_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: selects the byte/half lane from a read word and extends it.
module lsu_load_align
    import rv32i_types::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Extend the selected lane; unknown funct3 passes the full word.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'b0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory request per op, stalls
// until the response, then holds the formatted result until advance.
// Optional: define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_stage_lsu
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  rv32i_control_word ctrl_i,
    input  rv32i_data_word    data_i,
    input  logic              advance_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              load_valid_o,
    output logic              misalign_o,
    output logic [XLEN-1:0]   dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [MBE_W-1:0]  dmem_mbe,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp
);

    lsu_state_t       r_state;
    logic [XLEN-1:0]  r_addr;
    logic [MBE_W-1:0] r_mbe;
    logic [XLEN-1:0]  r_wdata;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic             r_is_load;
    logic             r_dmem_read;
    logic             r_dmem_write;
    logic [XLEN-1:0]  r_load_data;
    logic             r_load_valid;

    logic             w_is_write;
    logic             w_is_read;
    logic             w_start;
    logic [1:0]       w_off;
    acc_size_t        w_size;
    logic [MBE_W-1:0] w_mbe;
    logic [XLEN-1:0]  w_wdata;
    logic [XLEN-1:0]  w_load_fmt;

    // Write wins when decode asserts both.
    assign w_is_write = ctrl_i.dmem_write;
    assign w_is_read  = ctrl_i.dmem_read & ~ctrl_i.dmem_write;
    assign w_start    = (r_state == IDLE) & valid_i & (w_is_read | w_is_write);
    assign w_off      = data_i.alu_out[1:0];
    assign w_size     = acc_size(ctrl_i.funct3, w_is_write);

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        w_mbe   = 4'b1111;
        w_wdata = data_i.rs2_out;
        case (w_size)
            SZ_BYTE: begin
                w_mbe   = 4'(4'b0001 << w_off);
                w_wdata = {4{data_i.rs2_out[7:0]}};
            end
            SZ_HALF: begin
                w_mbe   = 4'(4'b0011 << {w_off[1], 1'b0});
                w_wdata = {2{data_i.rs2_out[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .o_data   (w_load_fmt)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign;
    assign w_misalign = ((w_size == SZ_HALF) & w_off[0]) |
                        ((w_size == SZ_WORD) & (w_off != 2'b00));
    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    // LSU FSM with request and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_mbe        <= '0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_is_load    <= 1'b0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr    <= {data_i.alu_out[XLEN-1:2], 2'b00};
                        r_mbe     <= w_mbe;
                        r_wdata   <= w_wdata;
                        r_funct3  <= ctrl_i.funct3;
                        r_off     <= w_off;
                        r_is_load <= w_is_read;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (w_misalign) begin
                            r_misalign   <= 1'b1;
                            r_load_data  <= '0;
                            r_load_valid <= w_is_read;
                            r_state      <= HOLD;
                        end else begin
                            r_dmem_read  <= w_is_read;
                            r_dmem_write <= w_is_write;
                            r_state      <= BUSY;
                        end
`else
                        r_dmem_read  <= w_is_read;
                        r_dmem_write <= w_is_write;
                        r_state      <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        r_load_data  <= w_load_fmt;
                        r_load_valid <= r_is_load;
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance_i) begin
                        r_load_valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                        r_misalign   <= 1'b0;
`endif
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_o      = w_start | (r_state == BUSY);
    assign dmem_address = r_addr;
    assign dmem_read    = r_dmem_read;
    assign dmem_write   = r_dmem_write;
    assign dmem_mbe     = r_mbe;
    assign dmem_wdata   = r_wdata;
    assign load_data_o  = r_load_data;
    assign load_valid_o = r_load_valid;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected requests and
// load results; a monitor pops and compares when the DUT presents them.
module tb_mem_stage_lsu;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    logic              valid_i;
    rv32i_control_word ctrl_i;
    rv32i_data_word    data_i;
    logic              advance_i;
    logic              stall_o;
    logic [31:0]       load_data_o;
    logic              load_valid_o;
    logic              misalign_o;
    logic [31:0]       dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [3:0]        dmem_mbe;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;

    mem_stage_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ctrl_i       (ctrl_i),
        .data_i       (data_i),
        .advance_i    (advance_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        mis;
    } ld_t;

    req_t req_q[$];
    ld_t  ld_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare on each new request and each new load result.
    initial begin : monitor
        logic prev_req;
        logic prev_lv;
        req_t e;
        ld_t  l;
        prev_req = 1'b0;
        prev_lv  = 1'b0;
        forever begin
            @(negedge clk);
            if ((dmem_read | dmem_write) && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    e = req_q.pop_front();
                    chk("req_read",  {31'b0, dmem_read},  {31'b0, e.rd});
                    chk("req_write", {31'b0, dmem_write}, {31'b0, e.wr});
                    chk("req_addr",  dmem_address, e.addr);
                    chk("req_mbe",   {28'b0, dmem_mbe}, {28'b0, e.mbe});
                    if (e.wr) chk("req_wdata", dmem_wdata, e.wdata);
                end
            end
            if (load_valid_o && !prev_lv) begin
                if (ld_q.size() == 0) begin
                    chk("unexpected_load", 32'd1, 32'd0);
                end else begin
                    l = ld_q.pop_front();
                    chk("load_data", load_data_o, l.data);
                    chk("load_misalign", {31'b0, misalign_o}, {31'b0, l.mis});
                end
            end
            prev_req = dmem_read | dmem_write;
            prev_lv  = load_valid_o;
        end
    end

    // One op: present in cycle 0, respond in cycle k, hold result for `hold` extra cycles.
    task automatic do_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int k, input int hold, input logic req_exp,
                         input logic [31:0] exp_addr, input logic [3:0] exp_mbe,
                         input logic [31:0] exp_wdata, input logic ld_exp_valid,
                         input logic [31:0] ld_exp, input logic mis_exp);
        req_t e;
        ld_t  l;
        valid_i           = 1'b1;
        ctrl_i.dmem_read  = rd;
        ctrl_i.dmem_write = wr;
        ctrl_i.funct3     = f3;
        data_i.alu_out    = addr;
        data_i.rs2_out    = rs2;
        if (req_exp) begin
            e.rd = rd & ~wr; e.wr = wr; e.addr = exp_addr; e.mbe = exp_mbe; e.wdata = exp_wdata;
            req_q.push_back(e);
        end
        if (ld_exp_valid) begin
            l.data = ld_exp; l.mis = mis_exp;
            ld_q.push_back(l);
        end
        @(negedge clk);
        chk({nm, "_stall_c0"}, {31'b0, stall_o}, 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        ctrl_i  = '0;
        data_i  = '0;
        if (req_exp) begin
            for (int c = 1; c <= k; c++) begin
                if (c == k) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge clk);
                chk({nm, "_stall_busy"}, {31'b0, stall_o}, 32'd1);
                chk({nm, "_req_busy"}, {31'b0, dmem_read | dmem_write}, 32'd1);
                chk({nm, "_addr_busy"}, dmem_address, exp_addr);
                @(posedge clk); #1;
                dmem_resp  = 1'b0;
                dmem_rdata = GARBAGE;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) advance_i = 1'b1;
            @(negedge clk);
            chk({nm, "_stall_hold"}, {31'b0, stall_o}, 32'd0);
            chk({nm, "_req_hold"}, {31'b0, dmem_read | dmem_write}, 32'd0);
            chk({nm, "_lvalid_hold"}, {31'b0, load_valid_o}, {31'b0, ld_exp_valid});
            if (ld_exp_valid) chk({nm, "_ldata_hold"}, load_data_o, ld_exp);
            chk({nm, "_mis_hold"}, {31'b0, misalign_o}, {31'b0, mis_exp});
            @(posedge clk); #1;
            advance_i = 1'b0;
        end
    endtask

    initial begin : stim
        rst        = 1'b1;
        valid_i    = 1'b0;
        ctrl_i     = '0;
        data_i     = '0;
        advance_i  = 1'b0;
        dmem_rdata = GARBAGE;
        dmem_resp  = 1'b0;
        #1;
        chk("rst_stall",  {31'b0, stall_o}, 32'd0);
        chk("rst_lvalid", {31'b0, load_valid_o}, 32'd0);
        chk("rst_ldata",  load_data_o, 32'd0);
        chk("rst_read",   {31'b0, dmem_read}, 32'd0);
        chk("rst_write",  {31'b0, dmem_write}, 32'd0);
        chk("rst_addr",   dmem_address, 32'd0);
        chk("rst_mbe",    {28'b0, dmem_mbe}, 32'd0);
        chk("rst_wdata",  dmem_wdata, 32'd0);
        chk("rst_mis",    {31'b0, misalign_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        //     name   rd    wr    f3     addr          rs2           rdata        k  hold req  exp_addr      mbe      wdata        ldv   ld             mis
        do_op("sw",   1'b0, 1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, GARBAGE,      3, 0, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
        do_op("sb",   1'b0, 1'b1, F3_B,  32'h0000_0203, 32'h1234_5678, GARBAGE,      1, 0, 1'b1, 32'h0000_0200, 4'b1000, 32'h7878_7878, 1'b0, 32'h0,         1'b0);
        do_op("lb",   1'b1, 1'b0, F3_B,  32'h0000_0301, 32'h0,         32'h0000_F000, 2, 0, 1'b1, 32'h0000_0300, 4'b0010, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b0);
        do_op("lbu",  1'b1, 1'b0, F3_BU, 32'h0000_0301, 32'h0,         32'h0000_F000, 1, 0, 1'b1, 32'h0000_0300, 4'b0010, 32'h0,         1'b1, 32'h0000_00F0, 1'b0);
        do_op("lh",   1'b1, 1'b0, F3_H,  32'h0000_0402, 32'h0,         32'h8001_0000, 2, 4, 1'b1, 32'h0000_0400, 4'b1100, 32'h0,         1'b1, 32'hFFFF_8001, 1'b0);
        do_op("sh",   1'b0, 1'b1, F3_H,  32'h0000_0106, 32'h9999_ABCD, GARBAGE,      1, 1, 1'b1, 32'h0000_0104, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0,         1'b0);
        do_op("lhu",  1'b1, 1'b0, F3_HU, 32'h0000_0400, 32'h0,         32'h1234_8765, 1, 0, 1'b1, 32'h0000_0400, 4'b0011, 32'h0,         1'b1, 32'h0000_8765, 1'b0);
        do_op("lw",   1'b1, 1'b0, F3_W,  32'h0000_0500, 32'h0,         32'hCAFE_F00D, 1, 0, 1'b1, 32'h0000_0500, 4'b1111, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0);
        do_op("rdwr", 1'b1, 1'b1, F3_W,  32'h0000_0600, 32'h1122_3344, GARBAGE,      2, 0, 1'b1, 32'h0000_0600, 4'b1111, 32'h1122_3344, 1'b0, 32'h0,         1'b0);
        do_op("sb1",  1'b0, 1'b1, F3_B,  32'h0000_0201, 32'h0000_00AB, GARBAGE,      1, 0, 1'b1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0,         1'b0);
        do_op("lunk", 1'b1, 1'b0, 3'b011, 32'h0000_0700, 32'h0,        32'h0BAD_F00D, 1, 0, 1'b1, 32'h0000_0700, 4'b1111, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        do_op("lwmis", 1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0,         32'h5566_7788, 1, 1, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0,         1'b1);
`else
        do_op("lwmis", 1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0,         32'h5566_7788, 1, 1, 1'b1, 32'h0000_0100, 4'b1111, 32'h0,         1'b1, 32'h5566_7788, 1'b0);
`endif

        // Reset while BUSY: request drops at once, a late response is ignored.
        begin
            req_t e;
            valid_i           = 1'b1;
            ctrl_i.dmem_read  = 1'b1;
            ctrl_i.dmem_write = 1'b0;
            ctrl_i.funct3     = F3_W;
            data_i.alu_out    = 32'h0000_0800;
            data_i.rs2_out    = 32'h0;
            e.rd = 1'b1; e.wr = 1'b0; e.addr = 32'h0000_0800; e.mbe = 4'b1111; e.wdata = 32'h0;
            req_q.push_back(e);
            @(negedge clk);
            chk("rstbusy_stall_c0", {31'b0, stall_o}, 32'd1);
            @(posedge clk); #1;
            valid_i = 1'b0;
            ctrl_i  = '0;
            data_i  = '0;
            @(negedge clk);
            chk("rstbusy_read_c1", {31'b0, dmem_read}, 32'd1);
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk("rstbusy_read_drop", {31'b0, dmem_read}, 32'd0);
            chk("rstbusy_stall_drop", {31'b0, stall_o}, 32'd0);
            #1;
            rst = 1'b0;
            @(posedge clk); #1;
            dmem_resp  = 1'b1;
            dmem_rdata = 32'h1357_9BDF;
            @(negedge clk);
            chk("late_resp_lvalid", {31'b0, load_valid_o}, 32'd0);
            chk("late_resp_read", {31'b0, dmem_read}, 32'd0);
            @(posedge clk); #1;
            dmem_resp  = 1'b0;
            dmem_rdata = GARBAGE;
            @(negedge clk);
            chk("late_resp_lvalid2", {31'b0, load_valid_o}, 32'd0);
            chk("late_resp_stall", {31'b0, stall_o}, 32'd0);
            chk("late_resp_ldata", load_data_o, 32'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("ld_q_drained", ld_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
